// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default geometry, pooling-FSM state type and the
// pixel-to-window index helper used by the max-pool layer.
package cnn_pkg;

  localparam int DATA_W   = 32;
  localparam int MAP_DIM  = 6;
  localparam int POOL_DIM = MAP_DIM / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  // 2x2 windows, stride 2, laid out row-major in the pooled map.
  function automatic int pool_index(input int row, input int col, input int pool_dim);
    return (row / 2) * pool_dim + (col / 2);
  endfunction

endpackage

// File: rtl/pool_idx_gen.sv
// Raster row/col tracker for the max-pool layer: produces the pooled-map
// window index, a first-pixel-of-window flag and a last-pixel-of-frame flag.
module pool_idx_gen
  import cnn_pkg::*;
#(
  parameter int MAP_DIM = cnn_pkg::MAP_DIM,
  parameter int CNT_W   = 3,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] win_idx,
  output logic             first_of_win,
  output logic             last_pixel
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(MAP_DIM - 1);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == LAST_POS) begin
        col_d = '0;
        row_d = (row_q == LAST_POS) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign win_idx      = IDX_W'(pool_index(int'(row_q), int'(col_q), MAP_DIM / 2));
  assign first_of_win = ~row_q[0] & ~col_q[0];
  assign last_pixel   = (row_q == LAST_POS) && (col_q == LAST_POS);

endmodule

// File: rtl/maxpool_layer.sv
// 2x2 / stride-2 max-pool over a raster pixel stream, one frame per enable.
// Define MAXPOOL_RELU_EN to clamp the pooled map at zero on entry to DONE.
module maxpool_layer
  import cnn_pkg::*;
#(
  parameter int MAP_DIM = cnn_pkg::MAP_DIM,
  parameter int DATA_W  = cnn_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] pool_out [0:(MAP_DIM/2)*(MAP_DIM/2)-1],
  output logic                     done,
  output logic                     busy
);

  localparam int POOL_SIDE = MAP_DIM / 2;
  localparam int POOL_N    = POOL_SIDE * POOL_SIDE;
  localparam int CNT_W     = (MAP_DIM > 2) ? $clog2(MAP_DIM) : 1;
  localparam int IDX_W     = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  generate
    if ((MAP_DIM % 2) != 0 || MAP_DIM < 2) begin : g_bad_map_dim
      $error("maxpool_layer: MAP_DIM must be even and at least 2");
    end
  endgenerate

  pool_state_t state_q, state_d;
  logic        done_q, done_d;
  logic signed [DATA_W-1:0] pool_q [0:POOL_N-1];
  logic signed [DATA_W-1:0] pool_d [0:POOL_N-1];

  logic             accept;
  logic             start;
  logic [IDX_W-1:0] win_idx;
  logic             first_of_win;
  logic             last_pixel;

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = done_q;
  assign accept   = in_ready && in_valid;
  assign start    = (state_q == IDLE) && enable;

  pool_idx_gen #(
    .MAP_DIM (MAP_DIM),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_idx (
    .clk          (clk),
    .rst          (rst),
    .clear        (start),
    .advance      (accept),
    .win_idx      (win_idx),
    .first_of_win (first_of_win),
    .last_pixel   (last_pixel)
  );

  always_comb begin
    state_d = state_q;
    pool_d  = pool_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          // First pixel of a window overwrites whatever the last frame left.
          if (first_of_win) begin
            pool_d[win_idx] = in_data;
          end else if (in_data > pool_q[win_idx]) begin
            pool_d[win_idx] = in_data;
          end
          if (last_pixel) state_d = DONE;
        end
      end
      DONE: begin
        // The first DONE cycle finalises the map; done is raised after it.
        if (!done_q) begin
`ifdef MAXPOOL_RELU_EN
          for (int i = 0; i < POOL_N; i++) begin
            if (pool_q[i][DATA_W-1]) pool_d[i] = '0;
          end
`endif
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  generate
    for (genvar gi = 0; gi < POOL_N; gi++) begin : g_pool
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pool_q[gi] <= '0;
        end else begin
          pool_q[gi] <= pool_d[gi];
        end
      end
      assign pool_out[gi] = pool_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_maxpool_layer.sv
// Directed + randomized bench for maxpool_layer against a window-max model.
module tb_maxpool_layer;

  localparam int MD = 6;
  localparam int DW = 32;
  localparam int NP = MD * MD;
  localparam int NW = (MD / 2) * (MD / 2);

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic signed [DW-1:0] pool_out [0:NW-1];
  logic                 done;
  logic                 busy;

  int checks;
  int failures;

  logic signed [DW-1:0] frame    [0:NP-1];
  logic signed [DW-1:0] exp_pool [0:NW-1];
  logic signed [DW-1:0] snap     [0:NW-1];

  maxpool_layer #(.MAP_DIM(MD), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .pool_out (pool_out),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_pool(input string tag);
    for (int i = 0; i < NW; i++) begin
      checks++;
      assert (pool_out[i] === exp_pool[i]) else begin
        failures++;
        $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, pool_out[i], exp_pool[i]);
      end
    end
  endtask

  // Reference: each output is the largest of the four pixels of its window.
  task automatic model_pool();
    for (int w = 0; w < NW; w++) begin
      int br, bc;
      logic signed [DW-1:0] m;
      br = (w / (MD / 2)) * 2;
      bc = (w % (MD / 2)) * 2;
      m = frame[br * MD + bc];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (frame[(br + dr) * MD + bc + dc] > m) m = frame[(br + dr) * MD + bc + dc];
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = 0;
`endif
      exp_pool[w] = m;
    end
  endtask

  // gap: 0 = in_valid always high, 1 = low on every other cycle (low first),
  // 2 = random. drop_after/abort_after < 0 disables those behaviours.
  task automatic run_frame(input int gap, input int drop_after, input int abort_after,
                           output int lat);
    int   idx;
    logic acc;
    idx = 0;
    lat = 0;
    enable = 1'b1;
    in_valid = 1'b0;
    step();
    while (idx < NP && lat < 400) begin
      if (abort_after >= 0 && idx == abort_after) break;
      case (gap)
        0:       in_valid = 1'b1;
        1:       in_valid = (lat % 2 == 1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = frame[idx];
      if (drop_after >= 0 && idx >= drop_after) enable = 1'b0;
      acc = in_valid && in_ready;
      step();
      lat++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    in_data = '0;
    if (abort_after < 0) begin
      check_int("pixels_accepted", idx, NP);
      check_bit("done_low_at_last_accept", done, 1'b0);
      while (!done && lat < 400) begin
        step();
        lat++;
      end
      check_bit("done_seen", done, 1'b1);
    end
  endtask

  task automatic hold_and_release(input string tag);
    for (int i = 0; i < NW; i++) snap[i] = pool_out[i];
    repeat (3) step();
    check_bit("done_held", done, 1'b1);
    for (int i = 0; i < NW; i++) begin
      checks++;
      assert (pool_out[i] === snap[i]) else begin
        failures++;
        $error("FAIL %s_stable[%0d] observed=%0d expected=%0d", tag, i, pool_out[i], snap[i]);
      end
    end
    enable = 1'b0;
    step();
    check_bit("done_after_release", done, 1'b0);
    check_bit("busy_after_release", busy, 1'b0);
  endtask

  initial begin
    int lat;
    checks = 0;
    failures = 0;
    enable = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b0);
    for (int i = 0; i < NW; i++) exp_pool[i] = '0;
    check_pool("reset_pool");
    repeat (2) step();
    rst = 1'b1;
    step();
    check_bit("idle_in_ready", in_ready, 1'b0);

    // Raster ramp 0..35
    for (int i = 0; i < NP; i++) frame[i] = i;
    run_frame(0, -1, -1, lat);
    $display("frame ramp latency=%0d", lat);
    check_int("ramp_latency", lat, 37);
    exp_pool = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
`ifdef MAXPOOL_RELU_EN
    model_pool();
`endif
    check_pool("ramp_pool");
    hold_and_release("ramp");

    // All -5 with a single -2 in window 0
    for (int i = 0; i < NP; i++) frame[i] = -5;
    frame[1 * MD + 1] = -2;
    run_frame(0, -1, -1, lat);
    $display("frame negative latency=%0d", lat);
`ifdef MAXPOOL_RELU_EN
    for (int i = 0; i < NW; i++) exp_pool[i] = 0;
`else
    for (int i = 0; i < NW; i++) exp_pool[i] = -5;
    exp_pool[0] = -2;
`endif
    check_pool("neg_pool");
    // Reset while DONE must drop done at once
    rst = 1'b0;
    #1;
    check_bit("async_reset_done", done, 1'b0);
    for (int i = 0; i < NW; i++) exp_pool[i] = '0;
    check_pool("async_reset_pool");
    enable = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Ramp with in_valid low every other cycle
    for (int i = 0; i < NP; i++) frame[i] = i;
    run_frame(1, -1, -1, lat);
    $display("frame gapped latency=%0d", lat);
    check_int("gap_latency", lat, 73);
    model_pool();
    check_pool("gap_pool");
    hold_and_release("gap");

    // Enable dropped after 10 pixels: frame completes, then IDLE
    for (int i = 0; i < NP; i++) frame[i] = $signed($urandom);
    run_frame(0, 10, -1, lat);
    $display("frame enable_drop latency=%0d", lat);
    check_int("drop_latency", lat, 37);
    model_pool();
    check_pool("drop_pool");
    step();
    check_bit("drop_done_cleared", done, 1'b0);
    check_bit("drop_idle_busy", busy, 1'b0);

    // Reset after 20 pixels, then a constant-4 frame
    for (int i = 0; i < NP; i++) frame[i] = 100 + i;
    run_frame(0, -1, 20, lat);
    rst = 1'b0;
    #1;
    check_bit("midload_reset_done", done, 1'b0);
    check_bit("midload_reset_busy", busy, 1'b0);
    check_bit("midload_reset_ready", in_ready, 1'b0);
    enable = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_bit("post_reset_idle", in_ready, 1'b0);
    for (int i = 0; i < NP; i++) frame[i] = 4;
    run_frame(0, -1, -1, lat);
    $display("frame const4 latency=%0d", lat);
    for (int i = 0; i < NW; i++) exp_pool[i] = 4;
    check_pool("const4_pool");
    hold_and_release("const4");

    // Tied maxima of 8 in window 0
    for (int i = 0; i < NP; i++) frame[i] = $signed(32'($urandom_range(0, 107))) - 100;
    frame[0] = 8;
    frame[1 * MD + 1] = 8;
    run_frame(0, -1, -1, lat);
    $display("frame tie latency=%0d", lat);
    model_pool();
    check_int("tie_pool0", int'(pool_out[0]), 8);
    check_pool("tie_pool");
    hold_and_release("tie");

    // Random full-range frames with random valid gaps
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NP; i++) frame[i] = $signed($urandom);
      run_frame(2, -1, -1, lat);
      $display("frame random%0d latency=%0d", f, lat);
      model_pool();
      check_pool("rand_pool");
      hold_and_release("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool_layer.md
MAXPOOL_LAYER -- requirements
Module: maxpool_layer

Interface
REQ-001 SHALL have parameter MAP_DIM, default 6, meaning input feature-map side length in pixels.
REQ-002 SHALL have parameter DATA_W, default 32, meaning signed pixel width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  start request; sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  in_data carries a valid pixel.
REQ-007 SHALL have port in_data  input  DATA_W signed  pixel stream, raster order, row 0 col 0 first.
REQ-008 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-009 SHALL have port pool_out  output  9 x DATA_W signed  unpacked array [0:8], 3x3 pooled map, index = (row/2)*3 + col/2.
REQ-010 SHALL have port done  output  1  pool_out complete and stable; drives downstream fc_layer enable.
REQ-011 SHALL have port busy  output  1  high in LOAD state.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-013 IDLE -> LOAD on enable=1; counters row=0, col=0 cleared on that edge.
REQ-014 in_ready SHALL equal 1 only in LOAD; a pixel is accepted when in_valid and in_ready are both 1.
REQ-015 On each accepted pixel with even row and even col, the addressed window register SHALL be loaded with in_data (no compare with stale value).
REQ-016 On other accepted pixels, window register SHALL become signed max(register, in_data); ties keep the register value.
REQ-017 col SHALL increment per accepted pixel, wrapping MAP_DIM-1 -> 0 with row increment; in_valid=0 cycles SHALL hold all counters and registers.
REQ-018 Accepting pixel (MAP_DIM-1, MAP_DIM-1) SHALL move LOAD -> DONE; done SHALL rise the cycle after that acceptance (latency 1 cycle).
REQ-019 In DONE, done=1 and pool_out SHALL stay constant; DONE -> IDLE when enable=0.
REQ-020 enable deassertion during LOAD SHALL be ignored; the frame completes.
REQ-021 pool_out SHALL update only in LOAD; reads during LOAD show partial results and are undefined to consumers.
REQ-022 Comparison SHALL be full-width signed; no saturation or truncation.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, row=col=0, done=0, busy=0, in_ready=0, all pool_out entries 0.
REQ-024 Reset mid-LOAD SHALL discard the partial frame; next frame starts only on a new enable after rst returns high.

Configuration
REQ-025 Macro MAXPOOL_RELU_EN defined: pool_out entries SHALL be max(window_max, 0), applied on entry to DONE.
REQ-026 Macro MAXPOOL_RELU_EN undefined: pool_out SHALL hold raw signed window maxima, negatives preserved.

Structure
REQ-027 Shared package cnn_pkg SHALL hold DATA_W, MAP_DIM, POOL_DIM (=MAP_DIM/2), and the pool_state_t enum {IDLE, LOAD, DONE}.
REQ-028 Sub-module pool_idx_gen SHALL hold row/col counters and output window index, first-of-window flag, and last-pixel flag.
REQ-029 MAP_DIM SHALL be even; an elaboration-time check SHALL fail on odd values.

Verification
REQ-030 Pixel value = raster index 0..35, in_valid always 1 -> done 37 cycles after enable edge; pool_out = {7,9,11,19,21,23,31,33,35}.
REQ-031 All pixels -5 except (1,1)=-2 -> pool_out[0]=-2, others -5 without MAXPOOL_RELU_EN; all 0 with it.
REQ-032 Same stream as REQ-030 with in_valid low every other cycle -> identical pool_out; done 73 cycles after start; counters hold during gaps.
REQ-033 rst pulsed low after 20 pixels, then new frame of constant 4 -> done=0 immediately on reset; final pool_out all 4.
REQ-034 enable dropped after 10 pixels -> frame completes, done=1 after 36th pixel; enable held low -> IDLE next cycle, done=0.
REQ-035 Window with equal maxima 8 at (0,0) and (1,1) -> pool_out[0]=8, no spurious update.
